// File: rtl/if_stage.sv
// Instruction-fetch stage: program memory, PC sequencing and the IF/ID pipeline register.
// Handles stall, jump redirect with a one-cycle bubble, and halt on HALT_OP.
module if_stage #(
    parameter int          MEM_DEPTH = 256,
    parameter logic [7:0]  RESET_PC  = 8'h00,
    parameter logic [7:0]  HALT_OP   = 8'hFF,
    parameter logic [7:0]  NOP_OP    = 8'h00
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       load_en,
    input  logic [7:0] load_addr,
    input  logic [7:0] load_data,
    input  logic       stall,
    input  logic       jump_en,
    input  logic [7:0] jump_target,
    output logic [7:0] PC,
    output logic [7:0] inst,
    output logic       valid,
    output logic       running,
    output logic       halted
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t     state, state_nxt;
    logic [7:0] pc_reg, pc_reg_nxt;
    logic [7:0] pc_p1, pc_p1_nxt;
    logic [7:0] inst_p1, inst_p1_nxt;
    logic       vld_p1, vld_p1_nxt;
    logic [7:0] fetch_p0;
    logic [7:0] mem [0:MEM_DEPTH-1];

    function automatic logic [7:0] pc_inc(input logic [7:0] a);
        return a + 8'd1;
    endfunction

    // Program memory is only writable while idle and survives reset.
    always_ff @(posedge clock) begin
        if (state == IDLE && load_en)
            mem[load_addr] <= load_data;
    end

    assign fetch_p0 = mem[pc_reg];

    always_comb begin
        state_nxt   = state;
        pc_reg_nxt  = pc_reg;
        pc_p1_nxt   = pc_p1;
        inst_p1_nxt = inst_p1;
        vld_p1_nxt  = vld_p1;
        case (state)
            IDLE: begin
                inst_p1_nxt = NOP_OP;
                vld_p1_nxt  = 1'b0;
                if (start) begin
                    state_nxt  = RUN;
                    pc_reg_nxt = RESET_PC;
                end
            end
            RUN: begin
                if (jump_en) begin
                    pc_reg_nxt  = jump_target;
                    inst_p1_nxt = NOP_OP;
                    vld_p1_nxt  = 1'b0;
                end else if (!stall) begin
                    inst_p1_nxt = fetch_p0;
                    pc_p1_nxt   = pc_inc(pc_reg);
                    vld_p1_nxt  = 1'b1;
                    // The halt word itself is delivered; pc_reg parks on it.
                    if (fetch_p0 == HALT_OP)
                        state_nxt = HALT;
                    else
                        pc_reg_nxt = pc_inc(pc_reg);
                end
            end
            HALT: begin
                inst_p1_nxt = NOP_OP;
                vld_p1_nxt  = 1'b0;
                if (start) begin
                    state_nxt  = RUN;
                    pc_reg_nxt = RESET_PC;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            pc_reg  <= RESET_PC;
            pc_p1   <= 8'h00;
            inst_p1 <= NOP_OP;
            vld_p1  <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc_reg  <= pc_reg_nxt;
            pc_p1   <= pc_p1_nxt;
            inst_p1 <= inst_p1_nxt;
            vld_p1  <= vld_p1_nxt;
        end
    end

    // IF/ID register outputs
    assign PC      = pc_p1;
    assign inst    = inst_p1;
    assign valid   = vld_p1;
    assign running = (state == RUN);
    assign halted  = (state == HALT);

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus a randomized run, all checked
// against a behavioural fetch model held in the bench.
module tb_if_stage;

    logic       clock = 1'b0;
    logic       reset, start, load_en, stall, jump_en;
    logic [7:0] load_addr, load_data, jump_target;
    logic [7:0] PC, inst;
    logic       valid, running, halted;

    int passes = 0;
    int checks = 0;

    // Behavioural model: 0 = idle, 1 = running, 2 = halted
    int         m_state;
    logic [7:0] m_mem [256];
    logic [7:0] m_pcr, m_pc, m_inst;
    logic       m_vld;

    if_stage dut (
        .clock(clock), .reset(reset), .start(start), .load_en(load_en),
        .load_addr(load_addr), .load_data(load_data), .stall(stall),
        .jump_en(jump_en), .jump_target(jump_target), .PC(PC), .inst(inst),
        .valid(valid), .running(running), .halted(halted)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_state = 0;
        m_pcr   = 8'h00;
        m_pc    = 8'h00;
        m_inst  = 8'h00;
        m_vld   = 1'b0;
    endtask

    task automatic model_step(input logic st, input logic ld, input logic [7:0] la,
                              input logic [7:0] ldd, input logic sl, input logic je,
                              input logic [7:0] jt);
        logic [7:0] w;
        if (m_state == 0) begin
            if (ld) m_mem[la] = ldd;
            m_inst = 8'h00;
            m_vld  = 1'b0;
            if (st) begin m_state = 1; m_pcr = 8'h00; end
        end else if (m_state == 1) begin
            if (je) begin
                m_pcr  = jt;
                m_inst = 8'h00;
                m_vld  = 1'b0;
            end else if (!sl) begin
                w      = m_mem[m_pcr];
                m_inst = w;
                m_pc   = 8'((int'(m_pcr) + 1) % 256);
                m_vld  = 1'b1;
                if (w == 8'hFF) m_state = 2;
                else            m_pcr = m_pc;
            end
        end else begin
            m_inst = 8'h00;
            m_vld  = 1'b0;
            if (st) begin m_state = 1; m_pcr = 8'h00; end
        end
    endtask

    task automatic cmp_model(input string where);
        chk({where, ".PC"}, PC, m_pc);
        chk({where, ".inst"}, inst, m_inst);
        chk({where, ".valid"}, {7'd0, valid}, {7'd0, m_vld});
        chk({where, ".running"}, {7'd0, running}, {7'd0, m_state == 1});
        chk({where, ".halted"}, {7'd0, halted}, {7'd0, m_state == 2});
    endtask

    task automatic tick(input logic st, input logic ld, input logic [7:0] la,
                        input logic [7:0] ldd, input logic sl, input logic je,
                        input logic [7:0] jt);
        start = st; load_en = ld; load_addr = la; load_data = ldd;
        stall = sl; jump_en = je; jump_target = jt;
        model_step(st, ld, la, ldd, sl, je, jt);
        @(posedge clock);
        #1;
        start = 0; load_en = 0; stall = 0; jump_en = 0;
        cmp_model("cyc");
    endtask

    task automatic idle_tick();             tick(0, 0, 8'h00, 8'h00, 0, 0, 8'h00); endtask
    task automatic load_w(input logic [7:0] a, input logic [7:0] d); tick(0, 1, a, d, 0, 0, 8'h00); endtask
    task automatic start_tick();            tick(1, 0, 8'h00, 8'h00, 0, 0, 8'h00); endtask

    // Assert reset between clock edges, check immediately, release after an edge.
    task automatic mid_reset();
        #2 reset = 1;
        #1;
        model_reset();
        chk("rst.PC", PC, 8'h00);
        chk("rst.inst", inst, 8'h00);
        chk("rst.valid", {7'd0, valid}, 8'h00);
        chk("rst.running", {7'd0, running}, 8'h00);
        chk("rst.halted", {7'd0, halted}, 8'h00);
        @(posedge clock);
        #1 reset = 0;
    endtask

    initial begin
        reset = 1; start = 0; load_en = 0; stall = 0; jump_en = 0;
        load_addr = 0; load_data = 0; jump_target = 0;
        model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;
        #3;
        cmp_model("por");
        @(posedge clock);
        #1 reset = 0;

        // Fill memory with non-halt words so every fetch is defined
        for (int i = 0; i < 256; i++) load_w(8'(i), 8'($urandom_range(0, 254)));

        // Program load, sequential fetch and halt
        load_w(8'h00, 8'h12); load_w(8'h01, 8'h16); load_w(8'h02, 8'hFF);
        start_tick();
        idle_tick(); chk("seq0.inst", inst, 8'h12); chk("seq0.PC", PC, 8'h01);
        idle_tick(); chk("seq1.inst", inst, 8'h16); chk("seq1.PC", PC, 8'h02);
        idle_tick(); chk("seq2.inst", inst, 8'hFF); chk("seq2.PC", PC, 8'h03);
        chk("seq2.halted", {7'd0, halted}, 8'h01);
        idle_tick(); chk("seq3.valid", {7'd0, valid}, 8'h00); chk("seq3.inst", inst, 8'h00);
        tick(0, 1, 8'h05, 8'h77, 1, 1, 8'h10);   // all ignored while halted

        // Restart from halt; load attempted while running must be ignored
        start_tick();
        tick(0, 1, 8'h01, 8'hEE, 0, 0, 8'h00); chk("rst0.inst", inst, 8'h12);
        idle_tick(); chk("ldign.inst", inst, 8'h16);
        idle_tick(); chk("halt2", {7'd0, halted}, 8'h01);

        // Stall, then jump with simultaneous stall
        mid_reset();
        load_w(8'h00, 8'h11); load_w(8'h01, 8'h22); load_w(8'h02, 8'h33); load_w(8'h03, 8'h44);
        load_w(8'h40, 8'h5A); load_w(8'h41, 8'hFF);
        start_tick();
        idle_tick(); idle_tick(); chk("st.pre", inst, 8'h22);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 8'h00, 8'h00, 1, 0, 8'h00);
            chk("st.inst", inst, 8'h22); chk("st.PC", PC, 8'h02);
        end
        idle_tick(); chk("st.post", inst, 8'h33);
        tick(0, 0, 8'h00, 8'h00, 1, 1, 8'h40);
        chk("jmp.valid", {7'd0, valid}, 8'h00); chk("jmp.inst", inst, 8'h00);
        idle_tick(); chk("jmp.tinst", inst, 8'h5A); chk("jmp.tPC", PC, 8'h41);
        chk("jmp.tvalid", {7'd0, valid}, 8'h01);
        idle_tick();

        // Wrap-around, then mid-run reset and replay
        mid_reset();
        load_w(8'hFF, 8'hA1); load_w(8'h00, 8'hB2); load_w(8'h01, 8'hFF);
        start_tick();
        tick(0, 0, 8'h00, 8'h00, 0, 1, 8'hFF);
        idle_tick(); chk("wrap.inst", inst, 8'hA1); chk("wrap.PC", PC, 8'h00);
        idle_tick(); chk("wrap2.inst", inst, 8'hB2); chk("wrap2.PC", PC, 8'h01);
        idle_tick();
        start_tick(); idle_tick();
        mid_reset();
        start_tick();
        idle_tick(); chk("replay.inst", inst, 8'hB2); chk("replay.PC", PC, 8'h01);

        // Randomized run against the model
        mid_reset();
        for (int i = 0; i < 256; i++)
            load_w(8'(i), ($urandom_range(0, 11) == 0) ? 8'hFF : 8'($urandom_range(0, 254)));
        start_tick();
        for (int i = 0; i < 1500; i++)
            tick($urandom_range(0, 19) == 0, $urandom_range(0, 7) == 0, 8'($urandom),
                 8'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                 8'($urandom));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 8-bit pipelined processor. It is the producer side of the IF/ID interface and drives the PC and inst inputs of the decode stage.
- Holds an internal 8-bit-wide program memory, which is loaded while the core is idle.
- Sequences the program counter and registers each fetched word into the IF/ID pipeline register.
- Handles stall, jump redirect with bubble insertion, and halt detection.

Parameters:
- MEM_DEPTH, 256, number of program memory words; address width is fixed at 8.
- RESET_PC, 8'h00, address of the first instruction fetched after start.
- HALT_OP, 8'hFF, opcode that stops fetching.
- NOP_OP, 8'h00, word injected into the IF/ID register as a bubble.

Ports:
- clock, input, 1, system clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high; clears all state except program memory.
- start, input, 1, single-cycle pulse; begins execution from RESET_PC.
- load_en, input, 1, program memory write enable; honoured only in IDLE.
- load_addr, input, 8, program memory write address.
- load_data, input, 8, program memory write data.
- stall, input, 1, hazard stall from decode; holds PC and IF/ID.
- jump_en, input, 1, taken jump or branch resolved downstream.
- jump_target, input, 8, absolute address to fetch next when jump_en=1.
- PC, output, 8, IF/ID register: address of the fetched instruction + 1.
- inst, output, 8, IF/ID register: fetched instruction word.
- valid, output, 1, IF/ID register: 1 when inst is a real fetched instruction.
- running, output, 1, 1 while in RUN.
- halted, output, 1, 1 while in HALT.

Behaviour:
- Internal state: pc_reg[7:0], FSM {IDLE, RUN, HALT}, and the memory mem[0:MEM_DEPTH-1].
- Reset (asynchronous, any state, including mid-fetch):
  - FSM=IDLE, pc_reg=RESET_PC, PC=0, inst=NOP_OP, valid=0.
  - mem contents are kept.
  - running and halted are decoded from FSM, so both are 0 during and after reset.
- IDLE:
  - If load_en=1, mem[load_addr]<=load_data.
  - If start=1, FSM<=RUN and pc_reg<=RESET_PC. A load in the same cycle still completes.
  - IF/ID holds NOP_OP with valid=0.
- RUN: per-cycle priority is jump_en > stall > halt detect > normal fetch. Memory reads are combinational on pc_reg.
  - Normal fetch: inst<=mem[pc_reg]; PC<=pc_reg+1; valid<=1; pc_reg<=pc_reg+1.
  - Arithmetic is mod 256, so pc_reg=8'hFF wraps to 8'h00 and PC also wraps.
  - Latency: a word at address A appears on inst one clock after pc_reg=A.
  - stall=1: pc_reg, PC, inst and valid all hold. Stalls of any length are legal.
  - jump_en=1: pc_reg<=jump_target; inst<=NOP_OP; valid<=0; PC holds. This is a one-cycle bubble. The target word appears on the following clock.
  - jump_en wins over a simultaneous stall.
  - Halt: mem[pc_reg]==HALT_OP with no jump or stall.
    - The HALT_OP word is latched normally (inst=HALT_OP, valid=1, PC=addr+1) and FSM<=HALT.
    - pc_reg is not advanced.
    - A jump in the same cycle squashes the halt and FSM stays RUN.
  - load_en and start are ignored in RUN.
- HALT:
  - Each cycle inst<=NOP_OP, valid<=0; PC and pc_reg hold.
  - jump_en, stall and load_en are ignored.
  - start=1: FSM<=RUN, pc_reg<=RESET_PC, and fetch resumes from RESET_PC.
- Outputs: running=(FSM==RUN) and halted=(FSM==HALT) are combinational from FSM; all other outputs are registered.
- Reading an address that was never loaded is undefined; the bench must load every address it fetches.

Test Plan:
- Program load and sequential fetch:
  - Stimulus: reset; in IDLE load mem[0..2]=8'h12,8'h16,8'hFF; pulse start.
  - Required: on successive clocks inst/PC/valid = 12/1/1, then 16/2/1, then FF/3/1.
  - After the FF fetch, halted=1, running=0, and the next cycle gives inst=00, valid=0.
- Stall:
  - Stimulus: mem[0..3]=8'h11,22,33,44; hold stall high for 3 cycles after the 8'h22 fetch.
  - Required: inst=22, PC=2 for all 3 cycles; 8'h33 appears on the clock after stall drops.
- Jump flush and priority:
  - Stimulus: mem[0x40]=8'h5A; assert jump_en with jump_target=8'h40 and stall=1 in the same cycle.
  - Required: next clock gives valid=0, inst=00; following clock gives inst=5A, PC=8'h41, valid=1.
- Wrap-around:
  - Stimulus: mem[FF]=8'hA1, mem[00]=8'hB2; jump to 8'hFF.
  - Required: inst=A1 with PC=00, then inst=B2 with PC=01.
- Load ignored in RUN, and restart:
  - Stimulus: while running, pulse load_en to mem[1] with data 8'hEE.
  - Required: the original word at address 1 is fetched later.
  - Stimulus: after halt, pulse start.
  - Required: fetch resumes at RESET_PC.
- Asynchronous reset mid-run:
  - Stimulus: assert reset between clock edges during RUN.
  - Required: immediately PC=0, inst=00, valid=0, running=0.
  - After release plus start, the memory program replays unchanged.
